// File: rtl/uart_pkg.sv
// Shared UART constants: default byte width and default TX FIFO depth.
package uart_pkg;

    localparam int UART_DATA_W            = 8;
    localparam int UART_TX_FIFO_DEPTH_DEF = 16;

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x DATA_W register array: synchronous write port, asynchronous read port.
// Shared by the TX and RX FIFOs; holds no reset so the array maps to plain flops/LUTRAM.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH  = UART_TX_FIFO_DEPTH_DEF,
    parameter int DATA_W = UART_DATA_W
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [DATA_W-1:0]        i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [DATA_W-1:0]        o_rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// First-word-fall-through transmit byte FIFO with level, empty/full and sticky overflow status.
// Optional low-water interrupt enabled by defining UART_TX_FIFO_THR_IRQ_EN.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = UART_TX_FIFO_DEPTH_DEF,
    parameter int DATA_W = UART_DATA_W
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_wr_valid,
    output logic                     o_wr_ready,
    input  logic [DATA_W-1:0]        i_wr_data,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [DATA_W-1:0]        o_data,
    input  logic                     i_flush,
    input  logic                     i_overflow_clr,
    input  logic [$clog2(DEPTH):0]   i_thr_level,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty,
    output logic                     o_full,
    output logic                     o_overflow,
    output logic                     o_thr_irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          empty;
    logic          full;
    logic          overflow;
    logic          push;
    logic          pop;
    logic          overflow_set;

    // Full blocks writes even when a pop happens the same cycle: no write-through bypass.
    assign push         = i_wr_valid && !full && !i_flush && !i_rst;
    assign pop          = !empty && i_ready && !i_flush && !i_rst;
    assign overflow_set = i_wr_valid && full;

    always_comb begin
        count_next = count;
        if (i_flush) begin
            count_next = '0;
        end else if (push && !pop) begin
            count_next = count + CW'(1);
        end else if (pop && !push) begin
            count_next = count - CW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (i_flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next;
            empty <= (count_next == '0);
            full  <= (count_next == CW'(DEPTH));
        end
    end

    // Set wins over clear; flush leaves the flag alone so software still sees the loss.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            overflow <= 1'b0;
        end else if (overflow_set) begin
            overflow <= 1'b1;
        end else if (i_overflow_clr) begin
            overflow <= 1'b0;
        end
    end

`ifdef UART_TX_FIFO_THR_IRQ_EN
    logic thr_irq;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            thr_irq <= 1'b0;
        end else begin
            thr_irq <= (count_next <= i_thr_level);
        end
    end

    assign o_thr_irq = thr_irq;
`else
    logic thr_unused;
    assign thr_unused = ^i_thr_level;
    assign o_thr_irq  = 1'b0;
`endif

    uart_fifo_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_mem (
        .i_clk   (i_clk),
        .i_we    (push),
        .i_waddr (wr_ptr),
        .i_wdata (i_wr_data),
        .i_raddr (rd_ptr),
        .o_rdata (o_data)
    );

    assign o_count    = count;
    assign o_empty    = empty;
    assign o_full     = full;
    assign o_wr_ready = !full;
    assign o_valid    = !empty;
    assign o_overflow = overflow;

endmodule
